fetch_seq_ctrl: RTL and testbench

- Sequences the program counter for the fetch stage.
- Holds the architectural PC.
- Issues single-outstanding requests to instruction memory.
- Buffers one fetched instruction toward decode.
- Applies redirects (target computed by the NPC unit for branch/jump) with correct squashing of stale in-flight fetches.

---
 rtl/fetch_seq_ctrl_if.sv | 18 +
 rtl/fetch_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_fetch_seq_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_seq_ctrl_if.sv
// rtl/fetch_seq_ctrl_if.sv - instruction memory request/response bus
interface fetch_seq_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// rtl/fetch_seq_ctrl.sv - fetch PC sequencer with single-outstanding imem and redirect squash
module fetch_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      redirect_valid,
  input  logic [31:0]               npc_i,
  fetch_seq_ctrl_if.master          imem,
  output logic                      inst_valid,
  output logic [31:0]               inst,
  output logic [31:0]               inst_pc,
  input  logic                      inst_ready,
  output logic [31:0]               pc_cur,
  output logic                      misalign_err,
  output logic [15:0]               flush_cnt
);

  typedef enum logic {ST_REQ, ST_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        misalign_q, misalign_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        can_issue;
  logic        req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      misalign_q   <= 1'b0;
      flush_cnt_q  <= 16'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      misalign_q   <= misalign_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  always_comb begin
    can_issue    = !inst_valid_q || inst_ready;
    // Gated by rst_n so the bus is quiet while reset is held.
    req          = rst_n && (state_q == ST_REQ) && can_issue && !redirect_valid;

    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    misalign_d   = 1'b0;
    flush_cnt_d  = flush_cnt_q;

    if (inst_valid_q && inst_ready) begin
      inst_valid_d = 1'b0;
    end

    case (state_q)
      ST_REQ: begin
        if (req && imem.imem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem.imem_rvalid) begin
          state_d = ST_REQ;
          if (kill_q) begin
            kill_d = 1'b0;
          end else begin
            inst_d       = imem.imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
          end
        end
      end
      default: state_d = ST_REQ;
    endcase

    // Redirect overrides everything above, including a same-cycle capture.
    if (redirect_valid) begin
      pc_d         = {npc_i[31:2], 2'b00};
      inst_valid_d = 1'b0;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      misalign_d   = |npc_i[1:0];
      if (flush_cnt_q != 16'hFFFF) begin
        flush_cnt_d = flush_cnt_q + 16'd1;
      end
      if (state_q == ST_WAIT) begin
        if (imem.imem_rvalid) begin
          kill_d  = 1'b0;
          state_d = ST_REQ;
        end else begin
          kill_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end else begin
        state_d = ST_REQ;
      end
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign pc_cur         = pc_q;
  assign misalign_err   = misalign_q;
  assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb/tb_fetch_seq_ctrl.sv - directed self-checking bench for fetch_seq_ctrl
module tb_fetch_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] npc_i;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [31:0] pc_cur;
  logic        misalign_err;
  logic [15:0] flush_cnt;

  int n_checks;
  int n_errors;

  fetch_seq_ctrl_if imem ();

  fetch_seq_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .npc_i          (npc_i),
    .imem           (imem.master),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .pc_cur         (pc_cur),
    .misalign_err   (misalign_err),
    .flush_cnt      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    redirect_valid     = 1'b0;
    npc_i              = 32'h0;
    inst_ready         = 1'b1;
    imem.imem_gnt      = 1'b0;
    imem.imem_rvalid   = 1'b0;
    imem.imem_rdata    = 32'h0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Grant in REQ, respond one cycle later, then check the captured instruction.
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] data);
    imem.imem_gnt    = 1'b1;
    imem.imem_rvalid = 1'b0;
    #1;
    check_eq("req_issue", 32'(imem.imem_req), 32'd1);
    check_eq("req_addr", imem.imem_addr, exp_addr);
    tick();
    imem.imem_gnt = 1'b0;
    check_eq("wait_no_req", 32'(imem.imem_req), 32'd0);
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = data;
    tick();
    imem.imem_rvalid = 1'b0;
    check_eq("cap_valid", 32'(inst_valid), 32'd1);
    check_eq("cap_pc", inst_pc, exp_addr);
    check_eq("cap_inst", inst, data);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset values while rst_n is held
    do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_req", 32'(imem.imem_req), 32'd0);
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_inst", inst, 32'd0);
    check_eq("rst_inst_pc", inst_pc, 32'd0);
    check_eq("rst_pc", pc_cur, 32'd0);
    check_eq("rst_misalign", 32'(misalign_err), 32'd0);
    check_eq("rst_flush", 32'(flush_cnt), 32'd0);
    rst_n = 1'b1;

    // Streaming fetch with decode always ready
    fetch_one(32'h0, 32'h0000_0013);
    fetch_one(32'h4, 32'h0000_0013);
    fetch_one(32'h8, 32'h0000_0013);

    // Decode backpressure holds the buffer and blocks new requests
    do_reset();
    inst_ready = 1'b0;
    fetch_one(32'h0, 32'h0000_0013);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_req", 32'(imem.imem_req), 32'd0);
      check_eq("bp_pc", inst_pc, 32'h0);
      check_eq("bp_inst", inst, 32'h0000_0013);
      tick();
    end
    inst_ready = 1'b1;
    fetch_one(32'h4, 32'h0000_0093);

    // Redirect after grant: stale response killed
    do_reset();
    fetch_one(32'h0, 32'hA000_0000);
    fetch_one(32'h4, 32'hA000_0004);
    imem.imem_gnt = 1'b1;
    #1;
    check_eq("g8_addr", imem.imem_addr, 32'h8);
    tick();
    imem.imem_gnt  = 1'b0;
    redirect_valid = 1'b1;
    npc_i          = 32'h100;
    #1;
    check_eq("rd1_req_masked", 32'(imem.imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    check_eq("rd1_flush", 32'(flush_cnt), 32'd1);
    check_eq("rd1_pc", pc_cur, 32'h100);
    check_eq("rd1_valid", 32'(inst_valid), 32'd0);
    check_eq("rd1_wait_req", 32'(imem.imem_req), 32'd0);
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem.imem_rvalid = 1'b0;
    check_eq("kill_drop", 32'(inst_valid), 32'd0);
    check_eq("kill_pc", pc_cur, 32'h100);
    fetch_one(32'h100, 32'h1111_1111);

    // Redirect coincident with rvalid: data dropped, no kill left behind
    imem.imem_gnt = 1'b1;
    #1;
    check_eq("g104_addr", imem.imem_addr, 32'h104);
    tick();
    imem.imem_gnt    = 1'b0;
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = 32'h0BAD_0BAD;
    redirect_valid   = 1'b1;
    npc_i            = 32'h200;
    tick();
    imem.imem_rvalid = 1'b0;
    redirect_valid   = 1'b0;
    check_eq("rd2_valid", 32'(inst_valid), 32'd0);
    check_eq("rd2_pc", pc_cur, 32'h200);
    check_eq("rd2_flush", 32'(flush_cnt), 32'd2);
    fetch_one(32'h200, 32'h2222_2222);

    // Misaligned redirect target in REQ
    redirect_valid = 1'b1;
    npc_i          = 32'h302;
    #1;
    check_eq("rd3_req_masked", 32'(imem.imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    check_eq("mis_set", 32'(misalign_err), 32'd1);
    check_eq("mis_pc", pc_cur, 32'h300);
    check_eq("mis_flush", 32'(flush_cnt), 32'd3);
    tick();
    check_eq("mis_clear", 32'(misalign_err), 32'd0);
    fetch_one(32'h300, 32'h3333_3333);

    // PC wraps at the top of the address space
    redirect_valid = 1'b1;
    npc_i          = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check_eq("wrap_flush", 32'(flush_cnt), 32'd4);
    fetch_one(32'hFFFF_FFFC, 32'h4444_4444);
    check_eq("wrap_pc", pc_cur, 32'h0);

    // Reset in the middle of WAIT
    imem.imem_gnt = 1'b1;
    tick();
    imem.imem_gnt = 1'b0;
    check_eq("mid_wait_req", 32'(imem.imem_req), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_valid", 32'(inst_valid), 32'd0);
    check_eq("mrst_inst", inst, 32'd0);
    check_eq("mrst_inst_pc", inst_pc, 32'd0);
    check_eq("mrst_pc", pc_cur, 32'd0);
    check_eq("mrst_flush", 32'(flush_cnt), 32'd0);
    check_eq("mrst_req", 32'(imem.imem_req), 32'd0);
    tick();
    rst_n            = 1'b1;
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = 32'hBEEF_0000;
    #1;
    check_eq("late_req", 32'(imem.imem_req), 32'd1);
    check_eq("late_addr", imem.imem_addr, 32'h0);
    tick();
    imem.imem_rvalid = 1'b0;
    check_eq("late_ignored", 32'(inst_valid), 32'd0);
    check_eq("late_pc", pc_cur, 32'h0);
    fetch_one(32'h0, 32'h0000_0013);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
